// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Command-side initiator for a combinational 4-op ALU. It reads
//                operands from a small register file, runs the ALU and writes
//                the result back, and returns each result on a valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_dst,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_rsp_done;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_cmd_ready;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_s;
  logic [AW-1:0]    r_dst;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [AW-1:0]    r_rsp_dst;
  logic             r_rsp_zero;

  always_comb begin
    w_accept     = cmd_valid & r_cmd_ready;
    w_rsp_done   = r_rsp_valid & rsp_ready;
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = cmd_load ? S_RESP : S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_dst       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_dst   <= '0;
      r_rsp_zero  <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      // Ready is registered, so it lags reset release by one edge.
      r_cmd_ready <= (w_state_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cmd_load) begin
              r_regs[cmd_dst] <= cmd_imm;
              r_rsp_valid     <= 1'b1;
              r_rsp_data      <= cmd_imm;
              r_rsp_dst       <= cmd_dst;
              r_rsp_zero      <= (cmd_imm == '0);
            end else begin
              r_alu_a <= r_regs[cmd_srca];
              r_alu_b <= r_regs[cmd_srcb];
              r_alu_s <= cmd_op;
              r_dst   <= cmd_dst;
            end
          end
        end
        S_EXEC: begin
          r_regs[r_dst] <= alu_y;
          r_rsp_valid   <= 1'b1;
          r_rsp_data    <= alu_y;
          r_rsp_dst     <= r_dst;
          r_rsp_zero    <= (alu_y == '0);
        end
        S_RESP: begin
          if (w_rsp_done) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_dst   = r_rsp_dst;
  assign rsp_zero  = r_rsp_zero;

endmodule
`default_nettype wire
